cache_read_arbiter: RTL and testbench

Shares the single read port (port B) of the parameter cache BRAM between two requesters: the AXI4-lite readback path (requester 0) and the LSTM compute engine's parameter fetch (requester 1). It runs a three-state sequencer with one outstanding read, round-robin grant, a registered response and valid/ready handshakes on both sides. It sits between the AXI slave's read channel logic and `simple_dual_one_clock`, and drives `enb`/`addrb` and consumes `dob`.

---
 rtl/lstm_pkg.sv | 14 +
 rtl/rr_arbiter_2.sv | 21 ++
 rtl/cache_read_arbiter.sv | 110 +++++++++++
 tb/tb_cache_read_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Shared types for the LSTM accelerator blocks: cache read arbiter states and
// requester ids.
package lstm_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    localparam logic REQ_AXI  = 1'b0;
    localparam logic REQ_LSTM = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick. The caller owns the last_grant pointer and updates
// it on every accepted grant.
module rr_arbiter_2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = valid0 | valid1;
        // On contention the requester that was not served last wins.
        if (valid0 && valid1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = valid1;
        end
    end

endmodule

// File: rtl/cache_read_arbiter.sv
// Shares cache BRAM port B between AXI readback (m0) and the LSTM parameter
// fetch (m1): one outstanding read, round-robin grant, registered response.
module cache_read_arbiter
    import lstm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req_valid,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    output logic                  m0_req_ready,
    output logic                  m0_rsp_valid,
    output logic [WIDTH-1:0]      m0_rsp_data,
    input  logic                  m0_rsp_ready,

    input  logic                  m1_req_valid,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    output logic                  m1_req_ready,
    output logic                  m1_rsp_valid,
    output logic [WIDTH-1:0]      m1_rsp_data,
    input  logic                  m1_rsp_ready,

    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [WIDTH-1:0]      bram_dout,

    output logic                  busy,
    output logic                  owner
);

    arb_state_t       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic grant_valid;
    logic grant_id;

    rr_arbiter_2 u_rr (
        .valid0      (m0_req_valid),
        .valid1      (m1_req_valid),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        bram_en      = 1'b0;
        bram_addr    = '0;

        case (state_q)
            ARB_IDLE: begin
                // rst gate keeps handshake outputs quiet while reset is held.
                if (rst && grant_valid) begin
                    m0_req_ready = (grant_id == REQ_AXI);
                    m1_req_ready = (grant_id == REQ_LSTM);
                    bram_en      = 1'b1;
                    bram_addr    = (grant_id == REQ_LSTM) ? m1_req_addr : m0_req_addr;
                    owner_d      = grant_id;
                    last_grant_d = grant_id;
                    state_d      = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                rsp_data_d = bram_dout;
                state_d    = ARB_RESP;
            end
            ARB_RESP: begin
                if ((owner_q == REQ_AXI) ? m0_rsp_ready : m1_rsp_ready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= REQ_AXI;
            last_grant_q <= REQ_LSTM;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign m0_rsp_valid = (state_q == ARB_RESP) && (owner_q == REQ_AXI);
    assign m1_rsp_valid = (state_q == ARB_RESP) && (owner_q == REQ_LSTM);
    assign m0_rsp_data  = rsp_data_q;
    assign m1_rsp_data  = rsp_data_q;
    assign busy         = (state_q != ARB_IDLE);
    assign owner        = owner_q;

endmodule

// File: tb/tb_cache_read_arbiter.sv
// Directed bench for cache_read_arbiter: transaction-level model checked every
// cycle plus literal expectations for the key scenarios.
module tb_cache_read_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_req_valid = 1'b0, m1_req_valid = 1'b0;
    logic [AW-1:0] m0_req_addr = '0, m1_req_addr = '0;
    logic          m0_req_ready, m1_req_ready;
    logic          m0_rsp_valid, m1_rsp_valid;
    logic [WIDTH-1:0] m0_rsp_data, m1_rsp_data;
    logic          m0_rsp_ready = 1'b0, m1_rsp_ready = 1'b0;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [WIDTH-1:0] bram_dout = '0;
    logic          busy, owner;

    int tests = 0;
    int fails = 0;

    cache_read_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req_valid (m0_req_valid),
        .m0_req_addr  (m0_req_addr),
        .m0_req_ready (m0_req_ready),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_data  (m0_rsp_data),
        .m0_rsp_ready (m0_rsp_ready),
        .m1_req_valid (m1_req_valid),
        .m1_req_addr  (m1_req_addr),
        .m1_req_ready (m1_req_ready),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_data  (m1_rsp_data),
        .m1_rsp_ready (m1_rsp_ready),
        .bram_en      (bram_en),
        .bram_addr    (bram_addr),
        .bram_dout    (bram_dout),
        .busy         (busy),
        .owner        (owner)
    );

    always #5 clk = ~clk;

    // Cache BRAM port B: registered read.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: a read occupies the port for a grant cycle, a data cycle, then
    // holds its response until the owner takes it.
    int   cyc = 0;
    int   phase = 0;          // 0 free, 1 read in flight, 2 response pending
    logic m_own = 1'b0;
    logic m_last = 1'b1;
    logic [WIDTH-1:0] m_data = '0;
    int   glog[$];
    int   gcyc[$];
    int   n_en = 0, n_busy = 0, n_rsp0 = 0, n_rsp1 = 0;

    always @(negedge clk) begin
        logic          e_gv, e_gid;
        logic [AW-1:0] e_addr;
        n_en   += int'(bram_en);
        n_busy += int'(busy);
        n_rsp0 += int'(m0_rsp_valid);
        n_rsp1 += int'(m1_rsp_valid);
        if (!rst) begin
            phase = 0; m_own = 1'b0; m_last = 1'b1; m_data = '0;
            chk("rst_req_ready", {m0_req_ready, m1_req_ready}, 2'b00);
            chk("rst_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 2'b00);
            chk("rst_rsp_data", m0_rsp_data, 32'h0);
            chk("rst_bram", {bram_en, bram_addr}, '0);
            chk("rst_busy_owner", {busy, owner}, 2'b00);
        end else begin
            e_gv   = (phase == 0) && (m0_req_valid || m1_req_valid);
            e_gid  = (m0_req_valid && m1_req_valid) ? !m_last : m1_req_valid;
            e_addr = e_gid ? m1_req_addr : m0_req_addr;
            chk("m0_req_ready", m0_req_ready, e_gv && !e_gid);
            chk("m1_req_ready", m1_req_ready, e_gv && e_gid);
            chk("bram_en", bram_en, e_gv);
            if (e_gv) chk("bram_addr", bram_addr, e_addr);
            chk("busy", busy, phase != 0);
            if (phase != 0) chk("owner", owner, m_own);
            chk("m0_rsp_valid", m0_rsp_valid, phase == 2 && !m_own);
            chk("m1_rsp_valid", m1_rsp_valid, phase == 2 && m_own);
            if (phase == 2) begin
                chk("m0_rsp_data", m0_rsp_data, m_data);
                chk("m1_rsp_data", m1_rsp_data, m_data);
            end
            if (e_gv) begin
                phase = 1; m_own = e_gid; m_last = e_gid; m_data = mem[e_addr];
                glog.push_back(int'(e_gid));
                gcyc.push_back(cyc);
            end else if (phase == 1) begin
                phase = 2;
            end else if (phase == 2 && (m_own ? m1_rsp_ready : m0_rsp_ready)) begin
                phase = 0;
            end
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base0, base1, base_en, base_busy;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h01] = 32'h0000_0011;
        mem[8'h02] = 32'h0000_0022;
        mem[8'h05] = 32'hCAFE_0005;

        step(3);
        rst = 1'b1;
        step(2);

        // Single read by m0.
        m0_req_valid = 1'b1; m0_req_addr = 8'h10; m0_rsp_ready = 1'b1;
        @(negedge clk);
        chk("single_req_ready_T", m0_req_ready, 1'b1);
        step(1);
        m0_req_valid = 1'b0;
        @(negedge clk);
        chk("single_no_rsp_T1", m0_rsp_valid, 1'b0);
        step(1);
        @(negedge clk);
        chk("single_rsp_valid_T2", m0_rsp_valid, 1'b1);
        chk("single_rsp_data_T2", m0_rsp_data, 32'hDEADBEEF);
        chk("single_m1_quiet", n_rsp1, 0);
        step(3);

        // Contention from reset.
        rst = 1'b0;
        step(2);
        m0_req_valid = 1'b1; m0_req_addr = 8'h01;
        m1_req_valid = 1'b1; m1_req_addr = 8'h02;
        m1_rsp_ready = 1'b1;
        glog.delete(); gcyc.delete();
        rst = 1'b1;
        step(12);
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        step(3);
        chk("cont_grants", glog.size(), 4);
        if (glog.size() >= 4) begin
            chk("cont_order", {glog[0][0], glog[1][0], glog[2][0], glog[3][0]}, 4'b0101);
            chk("cont_spacing_a", gcyc[1] - gcyc[0], 3);
            chk("cont_spacing_b", gcyc[3] - gcyc[2], 3);
        end

        // Backpressure on m1 while m0 waits.
        m1_rsp_ready = 1'b0;
        m1_req_valid = 1'b1; m1_req_addr = 8'h05;
        @(negedge clk);
        chk("bp_m1_granted", m1_req_ready, 1'b1);
        step(1);
        m1_req_valid = 1'b0;
        m0_req_valid = 1'b1; m0_req_addr = 8'h01;
        step(1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", m1_rsp_valid, 1'b1);
            chk("bp_rsp_data", m1_rsp_data, 32'hCAFE_0005);
            chk("bp_m0_blocked", m0_req_ready, 1'b0);
            step(1);
        end
        m1_rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_consume_cycle_m0_blocked", m0_req_ready, 1'b0);
        step(1);
        @(negedge clk);
        chk("bp_m0_next_grant", m0_req_ready, 1'b1);
        step(1);
        m0_req_valid = 1'b0;
        step(3);

        // Reset during WAIT.
        m0_req_valid = 1'b1; m0_req_addr = 8'h10;
        step(1);
        m0_req_valid = 1'b0;
        @(negedge clk);
        chk("rm_in_wait", busy, 1'b1);
        step(0);
        rst = 1'b0;
        #1;
        chk("rm_async_busy", busy, 1'b0);
        step(2);
        rst = 1'b1;
        base0 = n_rsp0; base1 = n_rsp1;
        step(4);
        chk("rm_no_stale_rsp", (n_rsp0 - base0) + (n_rsp1 - base1), 0);
        m0_req_valid = 1'b1; m1_req_valid = 1'b1;
        @(negedge clk);
        chk("rm_first_grant_m0", {m0_req_ready, m1_req_ready}, 2'b10);
        step(1);
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        step(4);

        // Idle with stray rsp_ready.
        m0_rsp_ready = 1'b1;
        base0 = n_rsp0; base1 = n_rsp1; base_en = n_en; base_busy = n_busy;
        step(20);
        chk("idle_bram_en", n_en - base_en, 0);
        chk("idle_busy", n_busy - base_busy, 0);
        chk("idle_rsp", (n_rsp0 - base0) + (n_rsp1 - base1), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
